// File: rtl/down_sampler_pkg.sv
// ---------------------------------------------------------------------------
// downsample_pkg
// Shared widths, rounding constant and phase encoding for the 2x2 box-filter
// decimator (down_sampler) and its line buffer (line_buf_ram).
// No ports: package only.
// ---------------------------------------------------------------------------
package downsample_pkg;

  // Row/column counters are wide enough for images up to 2048 pixels per side
  localparam int COL_W = 11;

  // Horizontal pair sum (two 8-bit pixels) and full 2x2 block sum
  localparam int SUM2_W = 9;
  localparam int SUM4_W = 10;

  // Added before the divide-by-4 so that x.5 rounds up
  localparam int ROUND_BIAS = 2;

  // Phase within a 2x2 block, encoded directly as {row[0], col[0]}
  typedef logic [1:0] phase_t;

  localparam phase_t EVEN_ROW_A = 2'b00;
  localparam phase_t EVEN_ROW_B = 2'b01;
  localparam phase_t ODD_ROW_A  = 2'b10;
  localparam phase_t ODD_ROW_B  = 2'b11;

endpackage

// File: rtl/down_sampler_line_buf_ram.sv
// ---------------------------------------------------------------------------
// line_buf_ram
// Simple dual-port synchronous RAM holding one half-row of horizontal pair
// sums. Write and read ports are independent; read data appears one clock
// after a read enable and is held until the next read enable.
//
// Ports:
//   clk      in   system clock
//   we       in   write enable
//   waddr    in   write address
//   wdata    in   write data (pair sum)
//   re       in   read enable
//   raddr    in   read address
//   rdata    out  registered read data
// ---------------------------------------------------------------------------
module line_buf_ram
  import downsample_pkg::*;
#(
  parameter int DEPTH = 800,
  parameter int AW    = 10,
  parameter int DW    = SUM2_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Contents are never reset: every entry is written during an even row
  // before the following odd row reads it. Writes and reads never target the
  // same cycle's entry because they happen on rows of opposite parity.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/down_sampler.sv
// ---------------------------------------------------------------------------
// down_sampler
// 2x2 box-filter decimator. Consumes an IN_WIDTH x IN_HEIGHT raster of 8-bit
// pixels from an upstream FIFO and emits one rounded average per 2x2 block,
// producing an (IN_WIDTH/2) x (IN_HEIGHT/2) image for the next octave.
//
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   valid       in   din holds a pixel this cycle
//   din[7:0]    in   input pixel, raster order
//   empty       in   upstream FIFO empty
//   rd_en       out  pop request to upstream FIFO
//   dout[7:0]   out  averaged output pixel (held until the next output)
//   valid_out   out  one-cycle strobe per output pixel
//   frame_done  out  pulses with the last output pixel of a frame
// ---------------------------------------------------------------------------
module down_sampler
  import downsample_pkg::*;
#(
  parameter int IN_WIDTH  = 1600,
  parameter int IN_HEIGHT = 1200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [7:0] din,
  input  logic       empty,
  output logic       rd_en,
  output logic [7:0] dout,
  output logic       valid_out,
  output logic       frame_done
);

  localparam int LB_DEPTH = IN_WIDTH / 2;
  localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IN_WIDTH - 1);
  localparam logic [COL_W-1:0] LAST_ROW = COL_W'(IN_HEIGHT - 1);

  logic [COL_W-1:0]  col_q, col_d;
  logic [COL_W-1:0]  row_q, row_d;
  logic [7:0]        a_q, a_d;
  logic [7:0]        dout_q, dout_d;
  logic              valid_out_q, valid_out_d;
  logic              frame_done_q, frame_done_d;

  logic              lb_we;
  logic              lb_re;
  logic [LB_AW-1:0]  lb_addr;
  logic [SUM2_W-1:0] lb_rdata;
  logic [SUM2_W-1:0] sum2;
  logic [SUM4_W-1:0] sum4;
  logic [1:0]        unused_frac;
  phase_t            phase;

  // There is no downstream backpressure, so the FIFO is popped whenever it
  // has data and the block is out of reset.
  assign rd_en = ~empty & ~rst;

  assign phase   = {row_q[0], col_q[0]};
  assign lb_addr = col_q[LB_AW:1];

  // Pair sum written during even rows, and the rounded block sum formed on
  // the odd-row odd-column pixel; the bias is folded in before the shift.
  assign sum2 = SUM2_W'(a_q) + SUM2_W'(din);
  assign sum4 = SUM4_W'(lb_rdata) + SUM4_W'(a_q) + SUM4_W'(din)
              + SUM4_W'(ROUND_BIAS);
  assign unused_frac = sum4[1:0];

  line_buf_ram #(
    .DEPTH (LB_DEPTH),
    .AW    (LB_AW),
    .DW    (SUM2_W)
  ) u_line_buf (
    .clk   (clk),
    .we    (lb_we),
    .waddr (lb_addr),
    .wdata (sum2),
    .re    (lb_re),
    .raddr (lb_addr),
    .rdata (lb_rdata)
  );

  // Next-state logic. Only valid cycles move the counters or touch the pair
  // latch and line buffer; idle cycles hold everything and drop valid_out.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    a_d          = a_q;
    dout_d       = dout_q;
    valid_out_d  = 1'b0;
    frame_done_d = 1'b0;
    lb_we        = 1'b0;
    lb_re        = 1'b0;

    if (valid) begin
      if (col_q == LAST_COL) begin
        col_d = '0;
        row_d = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end

      case (phase)
        EVEN_ROW_A: a_d = din;
        EVEN_ROW_B: lb_we = 1'b1;
        ODD_ROW_A: begin
          a_d   = din;
          lb_re = 1'b1;
        end
        ODD_ROW_B: begin
          dout_d       = sum4[SUM4_W-1:2];
          valid_out_d  = 1'b1;
          frame_done_d = (row_q == LAST_ROW) && (col_q == LAST_COL);
        end
        default: ;
      endcase
    end
  end

  // State registers. Reset discards any pending output and restarts the
  // raster at (0,0); stale line buffer entries are rewritten before use.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      a_q          <= '0;
      dout_q       <= '0;
      valid_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      a_q          <= a_d;
      dout_q       <= dout_d;
      valid_out_q  <= valid_out_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign dout       = dout_q;
  assign valid_out  = valid_out_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/down_sampler.md
Name: down_sampler

Overview:
- 2x2 box-filter decimator: consumes a raster image of IN_WIDTH x IN_HEIGHT 8-bit pixels from an upstream FIFO and emits an (IN_WIDTH/2) x (IN_HEIGHT/2) image, one averaged pixel per 2x2 input block.
- It is the inverse-direction partner of the 2x pixel/row up-sampler in the scale-space pipeline, used to build the next SIFT octave.
- A half-row line buffer holds the horizontal pair sums from each even row.

Parameters:
IN_WIDTH, 1600, input pixels per row; must be even, max 2048.
IN_HEIGHT, 1200, input rows per frame; must be even, max 2048.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
valid  input  1  din holds a pixel this cycle; FIFO asserts it exactly one cycle after an accepted rd_en
din  input  8  input pixel, raster order
empty  input  1  upstream FIFO empty
rd_en  output  1  pop request to upstream FIFO
dout  output  8  averaged output pixel
valid_out  output  1  dout valid this cycle
frame_done  output  1  one-cycle pulse coincident with the last output pixel of a frame

Behaviour:
- Reset values: rd_en=0, dout=0, valid_out=0, frame_done=0. Counters, pair latch and pipeline clear. The line buffer RAM is not cleared; it is always written in full before it is read.
- rd_en = ~empty & ~rst, combinational. There is no downstream backpressure; the consumer must accept every valid_out.
- Only cycles with valid=1 advance the counters. valid=0 cycles hold all state, and valid_out is 0 on those cycles unless a result is already in the pipeline.
- col counter (11b): runs 0..IN_WIDTH-1 and wraps to 0; on wrap, row increments.
- row counter (11b): runs 0..IN_HEIGHT-1 and wraps to 0 at frame end.
- State is the pair (row[0], col[0]): EVEN_ROW_A, EVEN_ROW_B, ODD_ROW_A, ODD_ROW_B.
  - EVEN_ROW_A (row even, col even): latch a <= din.
  - EVEN_ROW_B (row even, col odd): write line buffer[col>>1] <= a + din, 9-bit, no overflow. No output.
  - ODD_ROW_A (row odd, col even): latch a <= din. Issue a synchronous read of line buffer[col>>1]; data is available on the next valid cycle, and the read data register holds across valid gaps.
  - ODD_ROW_B (row odd, col odd): sum = lb_q + a + din, 10-bit; result = (sum + 2) >> 2 (round half up, max 255, no saturation needed). Register into dout.
- Timing of the ODD_ROW_B result:
  - valid_out=1 exactly one clk after the valid cycle of the odd-column pixel.
  - dout holds its value until the next output.
  - valid_out pulses for one cycle per output.
- Latency: 1 cycle from the last contributing input pixel (bottom-right of the block) to valid_out.
- frame_done=1 together with valid_out for block (row IN_HEIGHT-1, col IN_WIDTH-1); 0 otherwise.
- Output count per frame: exactly (IN_WIDTH/2)*(IN_HEIGHT/2). A back-to-back next frame starts at row 0 with no idle cycle required.
- Simultaneous events: a valid for the next pixel arriving on the same cycle that valid_out is asserted is normal operation and must not be dropped.
- Reset mid-frame: the pending output is discarded, valid_out is 0 on the cycle after rst, and counters restart at (0,0). Stale line buffer contents are overwritten before use.
- valid while empty was previously sampled high is an upstream protocol error. The block still trusts valid.

Decomposition:
- Shared package (downsample_pkg): COL_W=11, SUM2_W=9, SUM4_W=10, ROUND_BIAS=2, and the state encoding (2-bit, from {row[0],col[0]}).
- One natural sub-module: line_buf_ram, a simple dual-port synchronous RAM with IN_WIDTH/2 depth x 9 bits, 1-cycle read latency, and independent write and read ports.
- Top-level down_sampler holds the counters, pair latch, adder/round and output registers.

Test Plan:
- Constant image, all din=8'd100, IN_WIDTH=8, IN_HEIGHT=4 -> 8 outputs, all 100; frame_done on the 8th only.
- Block {10,20 / 30,41}, sum 101 -> dout=25 ((101+2)>>2=25). Block {1,1 / 1,2}, sum 5 -> dout=1. Block {255,255 / 255,255} -> 255 (no overflow).
- Ramp din=col+row*8 on an 8x4 image -> outputs 5,7,9,11,21,23,25,27, each valid_out exactly 1 cycle after the odd-row/odd-col input.
- Random valid gaps (e.g. 30% idle, FIFO toggling empty) -> output values and order identical to the gap-free run; rd_en=0 whenever empty=1.
- rst asserted for 1 cycle mid-way through row 1 -> no valid_out on the following cycle; the next full frame yields a correct, complete output set.
- Two frames back-to-back (default 1600x1200 params) -> exactly 480000 outputs per frame, frame_done twice, second frame values unaffected by first.
